// File: rtl/adder_tree_seq.sv
// Row sequencer for the 16-bank adder_tree: fetch row, wait for bank data, accumulate, report.
// Optional build macro ACC_SAT_EN: accumulator saturates at 2^ACC_W-1 instead of wrapping.
module adder_tree_seq #(
  parameter int SUM_W = 12,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] start_len,
  output logic             row_req,
  output logic [CNT_W-1:0] row_addr,
  input  logic             row_vld,
  input  logic [SUM_W-1:0] tree_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_nxt;

  // One extra bit catches the carry out of the accumulator.
  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, tree_sum};
    carry   = sum_ext[ACC_W];
`ifdef ACC_SAT_EN
    acc_nxt = (carry || ovf) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_nxt = sum_ext[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      len         <= '0;
      acc         <= '0;
      ovf         <= 1'b0;
      start_ready <= 1'b1;
      row_req     <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            len         <= start_len;
            acc         <= '0;
            ovf         <= 1'b0;
            cnt         <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            if (start_len == '0) begin
              state     <= RESP;
              res_valid <= 1'b1;
            end else begin
              state     <= FETCH;
              row_req   <= 1'b1;
            end
          end
        end
        FETCH: begin
          row_req <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (row_vld) begin
            acc <= acc_nxt;
            ovf <= ovf | carry;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(len - 1'b1)) begin
              state     <= RESP;
              res_valid <= 1'b1;
            end else begin
              state     <= FETCH;
              row_req   <= 1'b1;
            end
          end
        end
        RESP: begin
          if (res_ready) begin
            state       <= IDLE;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // acc, ovf and cnt only move in WAIT or at accept, so they are stable in RESP.
  assign row_addr = cnt;
  assign res_data = acc;
  assign res_ovf  = ovf;

endmodule

// File: tb/tb_adder_tree_seq.sv
// Directed bench for adder_tree_seq: a default-width instance and an ACC_W=16 instance in lockstep.
module tb_adder_tree_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic [7:0]  start_len;
  logic        row_vld;
  logic [11:0] tree_sum;
  logic        res_ready;

  logic        start_ready, row_req, res_valid, res_ovf, busy;
  logic [7:0]  row_addr;
  logic [19:0] res_data;

  logic        start_ready16, row_req16, res_valid16, res_ovf16, busy16;
  logic [7:0]  row_addr16;
  logic [15:0] res_data16;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  adder_tree_seq #(.SUM_W(12), .ACC_W(20), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .start_len(start_len),
    .row_req(row_req), .row_addr(row_addr), .row_vld(row_vld), .tree_sum(tree_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .busy(busy)
  );

  adder_tree_seq #(.SUM_W(12), .ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready16), .start_len(start_len),
    .row_req(row_req16), .row_addr(row_addr16), .row_vld(row_vld), .tree_sum(tree_sum),
    .res_valid(res_valid16), .res_ready(res_ready), .res_data(res_data16),
    .res_ovf(res_ovf16), .busy(busy16)
  );

  always @(negedge clk) if (row_req) req_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    start_valid = 1'b1;
    start_len   = 8'(len);
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!row_req && n < 50) begin tick(); n++; end
    chk(tag, 32'(row_req), 32'd1);
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 50) begin tick(); n++; end
    chk(tag, 32'(res_valid), 32'd1);
  endtask

  // Bank model: answer the pending row_req after 'dly' extra WAIT cycles.
  task automatic do_row(input string tag, input int addr, input int sum, input int dly,
                        input bit spur);
    wait_req({tag, "_req"});
    chk({tag, "_addr"}, 32'(row_addr), 32'(addr));
    if (spur) begin row_vld = 1'b1; tree_sum = 12'd999; end
    tick();
    row_vld = 1'b0;
    chk({tag, "_req_low"}, 32'(row_req), 32'd0);
    repeat (dly) tick();
    row_vld  = 1'b1;
    tree_sum = 12'(sum);
    tick();
    row_vld  = 1'b0;
    tree_sum = '0;
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(res_valid), 32'd0);
    chk({tag, "_sr_back"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    int r0;
    rst_n = 1'b0; start_valid = 1'b0; start_len = '0;
    row_vld = 1'b0; tree_sum = '0; res_ready = 1'b0;
    #12;
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_row_req", 32'(row_req), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // T1: 4 rows of 4080, immediate bank response
    start_job(4);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_sr_low", 32'(start_ready), 32'd0);
    for (int i = 0; i < 4; i++) do_row("t1_row", i, 4080, 0, 1'b0);
    wait_res("t1_res");
    chk("t1_data", 32'(res_data), 32'd16320);
    chk("t1_ovf", 32'(res_ovf), 32'd0);
    handshake("t1");

    // T2: zero-length job
    r0 = req_cnt;
    start_job(0);
    chk("t2_res_valid", 32'(res_valid), 32'd1);
    chk("t2_data", 32'(res_data), 32'd0);
    handshake("t2");
    chk("t2_no_req", 32'(req_cnt - r0), 32'd0);

    // T3: late bank response and stalled consumer
    start_job(2);
    do_row("t3_r0", 0, 510, 0, 1'b0);
    do_row("t3_r1", 1, 798, 7, 1'b0);
    wait_res("t3_res");
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_data", 32'(res_data), 32'd1308);
      chk("t3_hold_vld", 32'(res_valid), 32'd1);
      tick();
    end
    handshake("t3");

    // T4: 17 x 4080 overflows 16 bits but not 20
    start_job(17);
    for (int i = 0; i < 17; i++) do_row("t4_row", i, 4080, 0, 1'b0);
    wait_res("t4_res");
    chk("t4_data20", 32'(res_data), 32'd69360);
    chk("t4_ovf20", 32'(res_ovf), 32'd0);
    chk("t4_ovf16", 32'(res_ovf16), 32'd1);
`ifdef ACC_SAT_EN
    chk("t4_data16", 32'(res_data16), 32'd65535);
`else
    chk("t4_data16", 32'(res_data16), 32'd3824);
`endif
    handshake("t4");

    // T5: async reset while waiting on row 2 of 4
    start_job(4);
    do_row("t5_r0", 0, 1000, 0, 1'b0);
    do_row("t5_r1", 1, 1000, 0, 1'b0);
    wait_req("t5_r2_req");
    chk("t5_r2_addr", 32'(row_addr), 32'd2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_sr", 32'(start_ready), 32'd1);
    chk("t5_req", 32'(row_req), 32'd0);
    chk("t5_addr", 32'(row_addr), 32'd0);
    chk("t5_data", 32'(res_data), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    row_vld = 1'b1; tree_sum = 12'd4080;
    tick();
    row_vld = 1'b0; tree_sum = '0;
    chk("t5_stray_busy", 32'(busy), 32'd0);
    chk("t5_stray_data", 32'(res_data), 32'd0);
    start_job(1);
    do_row("t5_j2", 0, 100, 0, 1'b0);
    wait_res("t5_j2_res");
    chk("t5_j2_data", 32'(res_data), 32'd100);
    handshake("t5");

    // T6: start_valid held high, spurious row_vld in FETCH and RESP
    r0 = req_cnt;
    start_valid = 1'b1; start_len = 8'd3;
    tick();
    do_row("t6_r0", 0, 100, 1, 1'b1);
    chk("t6_sr_low", 32'(start_ready), 32'd0);
    do_row("t6_r1", 1, 200, 1, 1'b1);
    do_row("t6_r2", 2, 300, 1, 1'b1);
    wait_res("t6_res");
    row_vld = 1'b1; tree_sum = 12'd777;
    tick(); tick();
    row_vld = 1'b0; tree_sum = '0;
    chk("t6_data", 32'(res_data), 32'd600);
    chk("t6_reqs", 32'(req_cnt - r0), 32'd3);
    start_valid = 1'b0;
    handshake("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
